// File: rtl/psum_packetizer_rr.sv
// psum_packetizer_rr
//   Round-robin packetizer for partial-sum / final-output words from NCH adder
//   channels. Each accepted word is wrapped in a PWIDTH-bit NoC packet
//   {TYPE_BIT, DEST_ADDR, src, filler, data} and buffered in a FIFO_DEPTH-entry
//   FIFO that feeds the router.
//
// Optional build macro: PKT_SEQ_TAG_EN
//   When defined, the low 8 filler bits carry an 8-bit accept sequence number
//   and the remaining filler bits come from FILL[FW-1:8].
//   When undefined, the filler is FILL (truncated or zero-extended to FW).
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous reset, active-high
//   in_valid    [NCH]         per-channel data valid
//   in_ready    [NCH]         per-channel accept (only the arbitration winner)
//   in_data     [NCH*DWIDTH]  channel i at bits [i*DWIDTH +: DWIDTH]
//   out_valid   packet available at the FIFO head
//   out_ready   router accepts the head packet
//   out_packet  [PWIDTH]      head packet (last popped packet when empty)
//   pkt_count   [16]          packets delivered since reset (wraps)
//   fifo_level  [clog2(FIFO_DEPTH)+1] current occupancy
module psum_packetizer_rr #(
    parameter int          DWIDTH     = 8,
    parameter int          PWIDTH     = 47,
    parameter int          NCH        = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic        TYPE_BIT   = 1'b1,
    parameter logic [2:0]  DEST_ADDR  = 3'b110,
    parameter logic [2:0]  SRC_BASE   = 3'b100,
    parameter logic [31:0] FILL       = 32'h0000_FFFF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NCH-1:0]                    in_valid,
    output logic [NCH-1:0]                    in_ready,
    input  logic [NCH*DWIDTH-1:0]             in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PWIDTH-1:0]                 out_packet,
    output logic [15:0]                       pkt_count,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    localparam int FW = PWIDTH - 7 - DWIDTH;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [FW-1:0] FILL_FW = FW'(FILL);

    logic [DWIDTH-1:0] w_lane [NCH];
    logic [CW-1:0]     w_win;
    logic              w_any;
    logic [NCH-1:0]    w_ready;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_src;
    logic [FW-1:0]     w_fill;
    logic [PWIDTH-1:0] w_pkt;

    logic [CW-1:0]     r_rr;
    logic [PWIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic [PWIDTH-1:0] r_last;
    logic [15:0]       r_count;

    // ---- arbitration: first valid channel at or after r_rr, with wrap ----
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < NCH; i++) begin
            w_lane[i] = in_data[i*DWIDTH +: DWIDTH];
        end
        for (int k = 0; k < NCH; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!w_any && in_valid[CW'(idx)]) begin
                w_any = 1'b1;
                w_win = CW'(idx);
            end
        end
    end

    // A full FIFO blocks acceptance even when a pop happens in the same cycle.
    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_pop  = out_valid & out_ready;
    assign w_push = w_any & ~w_full & ~rst;

    always_comb begin
        w_ready = '0;
        if (w_push) w_ready[w_win] = 1'b1;
    end
    assign in_ready = w_ready;

    assign w_src = SRC_BASE + 3'(w_win);

`ifdef PKT_SEQ_TAG_EN
    logic [7:0] r_seq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_seq <= '0;
        else if (w_push) r_seq <= r_seq + 8'd1;
    end

    if (FW > 8) begin : g_fill_hi
        assign w_fill = {FILL_FW[FW-1:8], r_seq};
    end else begin : g_fill_lo
        assign w_fill = r_seq;
    end
`else
    assign w_fill = FILL_FW;
`endif

    assign w_pkt = {TYPE_BIT, DEST_ADDR, w_src, w_fill, w_lane[w_win]};

    // ---- FIFO control, rr pointer, delivered counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_last  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
                r_rr   <= (int'(w_win) == NCH - 1) ? '0 : w_win + CW'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_last  <= r_mem[r_rptr];
                r_count <= r_count + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---- FIFO storage (data only, never reset) ----
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_pkt;
    end

    // When empty the output keeps showing the last delivered packet.
    assign out_valid  = (r_level != '0);
    assign out_packet = out_valid ? r_mem[r_rptr] : r_last;
    assign pkt_count  = r_count;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_psum_packetizer_rr.sv
module tb_psum_packetizer_rr;

    localparam int PW = 47;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_packet;
    logic [15:0]   pkt_count;
    logic [2:0]    fifo_level;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef PKT_SEQ_TAG_EN
    localparam logic [PW-1:0] PMASK = ~(47'hFF << 8);
`else
    localparam logic [PW-1:0] PMASK = '1;
`endif

    psum_packetizer_rr dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .pkt_count  (pkt_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkpkt(input logic [2:0] src, input logic [7:0] d);
        return {1'b1, 3'b110, src, 32'h0000_FFFF, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] d);
        in_data[i*8 +: 8] = d;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    logic [3:0] exp_rdy;
    logic [7:0] drain [4];

    initial begin
        rst = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_packet", out_packet, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_level", fifo_level, 0);
        tick(); tick();
        rst = 1'b0;

        // single word from channel 0
        set_lane(0, 8'h5A); in_valid = 4'b0001; out_ready = 1'b1;
        #1;
        chk("t1_in_ready", in_ready, 4'b0001);
        tick();
        in_valid = '0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_level", fifo_level, 1);
        chk("t1_packet", out_packet & PMASK, mkpkt(3'b100, 8'h5A) & PMASK);
        chk("t1_cnt_before", pkt_count, 0);
        tick();
        chk("t1_cnt_after", pkt_count, 1);
        chk("t1_empty", out_valid, 0);
        chk("t1_hold_last", out_packet & PMASK, mkpkt(3'b100, 8'h5A) & PMASK);

        // all channels streaming, round-robin order
        do_reset();
        in_valid = 4'hF; out_ready = 1'b1;
        set_lane(0, 8'd1); set_lane(1, 8'd2); set_lane(2, 8'd3); set_lane(3, 8'd4);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'(1 << (k % 4));
            chk("rr_in_ready", in_ready, exp_rdy);
            tick();
            chk("rr_packet", out_packet & PMASK,
                mkpkt(3'(3'b100 + 3'(k % 4)), 8'(k % 4 + 1)) & PMASK);
            chk("rr_level", fifo_level, 1);
        end
        in_valid = '0;
        tick();
        chk("rr_cnt", pkt_count, 8);
        chk("rr_level_end", fifo_level, 0);

        // backpressure: ch2 streaming into a stalled router
        do_reset();
        in_valid = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            set_lane(2, 8'(8'h20 + k));
            #1;
            chk("bp_in_ready", in_ready, (k < 4) ? 4'b0100 : 4'b0000);
            tick();
            chk("bp_head_stable", out_packet & PMASK, mkpkt(3'b110, 8'h20) & PMASK);
        end
        chk("bp_level_full", fifo_level, 4);

        // full with simultaneous pop: no accept that cycle
        out_ready = 1'b1;
        set_lane(2, 8'h30);
        #1;
        chk("full_pop_ready", in_ready, 4'b0000);
        tick();
        chk("full_pop_level", fifo_level, 3);
        chk("full_pop_head", out_packet & PMASK, mkpkt(3'b110, 8'h21) & PMASK);
        out_ready = 1'b0;
        #1;
        chk("refill_ready", in_ready, 4'b0100);
        tick();
        chk("refill_level", fifo_level, 4);
        in_valid = '0; out_ready = 1'b1;
        drain[0] = 8'h21; drain[1] = 8'h22; drain[2] = 8'h23; drain[3] = 8'h30;
        for (int j = 0; j < 4; j++) begin
            chk("drain_head", out_packet & PMASK, mkpkt(3'b110, drain[j]) & PMASK);
            tick();
        end
        chk("drain_level", fifo_level, 0);
        chk("drain_valid", out_valid, 0);
        chk("drain_cnt", pkt_count, 5);

        // asynchronous reset with three packets buffered
        out_ready = 1'b0; in_valid = 4'b0001; set_lane(0, 8'h77);
        tick(); tick(); tick();
        chk("ar_level_pre", fifo_level, 3);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_level", fifo_level, 0);
        chk("ar_cnt", pkt_count, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_packet", out_packet, 0);
        rst = 1'b0;
        in_valid = '0;
        tick();
        chk("ar_stays_empty", out_valid, 0);

`ifdef PKT_SEQ_TAG_EN
        // sequence tag wraps after 256 accepts
        do_reset();
        in_valid = 4'b0001; set_lane(0, 8'h11); out_ready = 1'b1;
        for (int k = 0; k < 257; k++) begin
            tick();
            chk("seq_tag", out_packet[15:8], 8'(k));
        end
        chk("seq_fill_hi", out_packet[39:16], 24'h0000FF);
        in_valid = '0;
        tick();
        chk("seq_cnt", pkt_count, 257);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
